// File: rtl/seq_mul_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : seq_mul_unit
//  Description : Iterative radix-2 shift-add multiplier. Accepts a request in
//                IDLE, runs WIDTH add/shift iterations, then pulses done_o
//                for one cycle with the 2*WIDTH-bit product.
//  Ports       : clk_i        - clock, rising edge
//                rst_i        - asynchronous, active-low reset
//                start_i      - request strobe, sampled only in IDLE
//                signed_i     - 1: two's-complement operands, 0: unsigned
//                src1_i       - multiplicand
//                src2_i       - multiplier
//                busy_o       - high while calculating or presenting result
//                done_o       - one-cycle pulse, result valid this cycle
//                result_o     - low half of the product
//                result_hi_o  - high half of the product
//                zero_o       - full product equals zero
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o
);

    localparam int                 CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      c_LAST   = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_ONE    = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] c_ONE2   = (2*WIDTH)'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mplr;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic [WIDTH-1:0] r_result_lo;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH-1:0] w_prod_mag;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = (r_state == S_IDLE) && start_i;
    assign w_last   = (r_state == S_CALC) && (r_cnt == c_LAST);

    // Magnitudes: -2^(W-1) negates to itself, which read unsigned is the
    // correct magnitude 2^(W-1).
    assign w_abs1 = (signed_i && src1_i[WIDTH-1]) ? (~src1_i + c_ONE) : src1_i;
    assign w_abs2 = (signed_i && src2_i[WIDTH-1]) ? (~src2_i + c_ONE) : src2_i;

    // One iteration: conditional add into the upper half with carry kept,
    // then {carry, acc, mplr} shifted right by one.
    assign w_addend   = r_mplr[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_prod_mag = {w_sum, r_mplr[WIDTH-1:1]};
    assign w_prod     = r_neg ? (~w_prod_mag + c_ONE2) : w_prod_mag;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next_state = S_CALC;
            S_CALC:  if (r_cnt == c_LAST) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            S_CALC:  busy_o = 1'b1;
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_mcand     <= '0;
            r_acc       <= '0;
            r_mplr      <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_result_lo <= '0;
            r_result_hi <= '0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_mcand <= w_abs1;
            r_mplr  <= w_abs2;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
        end else if (r_state == S_CALC) begin
            r_acc  <= w_sum[WIDTH:1];
            r_mplr <= {w_sum[0], r_mplr[WIDTH-1:1]};
            r_cnt  <= r_cnt + CW'(1);
            if (w_last) begin
                r_result_lo <= w_prod[WIDTH-1:0];
                r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
                // Taken from the magnitude so a negative-signed zero still
                // reports zero.
                r_zero      <= (w_prod_mag == '0);
            end
        end
    end

    assign result_o    = r_result_lo;
    assign result_hi_o = r_result_hi;
    assign zero_o      = r_zero;

endmodule
`default_nettype wire
